// File: rtl/blob_frame_ctrl_if.sv
// Handshake bundle between the camera/core side and the blob frame controller.
// The controller takes the slave view; whoever drives the camera and core takes the master view.
interface blob_frame_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             i_start;
   logic             i_continuous;
   logic             i_abort;
   logic             i_frame_start;
   logic             i_pix_valid;
   logic             i_pix_bin;
   logic             o_blob_start;
   logic             o_blob_seq;
   logic             i_blob_valid;
   logic [CNT_W-1:0] i_blob_count;
   logic [CNT_W-1:0] o_count;
   logic             o_count_valid;
   logic             o_busy;
   logic [2:0]       o_state;
   logic             o_timeout;
   logic             o_gap_err;

   modport master (
      output i_start, i_continuous, i_abort, i_frame_start, i_pix_valid, i_pix_bin,
      output i_blob_valid, i_blob_count,
      input  o_blob_start, o_blob_seq, o_count, o_count_valid, o_busy, o_state,
      input  o_timeout, o_gap_err
   );

   modport slave (
      input  i_start, i_continuous, i_abort, i_frame_start, i_pix_valid, i_pix_bin,
      input  i_blob_valid, i_blob_count,
      output o_blob_start, o_blob_seq, o_count, o_count_valid, o_busy, o_state,
      output o_timeout, o_gap_err
   );
endinterface

// File: rtl/blob_frame_ctrl.sv
// Frame sequencer for the blob counter core: arms, aligns to frame start, streams one frame
// of binary pixels to the core, then latches the core's result or flags a timeout.
module blob_frame_ctrl #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int TIMEOUT    = 4096,
   parameter int FRAME_SKIP = 0,
   parameter int CNT_W      = 8
) (
   input logic               i_clk,
   input logic               i_rst_n,
   blob_frame_ctrl_if.slave  bus
);

   localparam int PIXELS = IMG_W * IMG_H;
   localparam int PIX_W  = $clog2(PIXELS);
   localparam int TMO_W  = $clog2(TIMEOUT);
   localparam int SKIP_W = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      START  = 3'd2,
      STREAM = 3'd3,
      WAIT   = 3'd4
   } state_t;

   state_t           state;
   logic [PIX_W-1:0] pix_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [SKIP_W-1:0] skip_cnt;
   logic             discard;
   logic             blob_start;
   logic             count_valid;
   logic             timeout;
   logic             gap_err;
   logic [CNT_W-1:0] count;
   logic             drop;

   // An abort takes effect on its own cycle, so the pixel under it is already forced to 0.
   assign drop = discard | bus.i_abort;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         pix_cnt     <= '0;
         tmo_cnt     <= '0;
         skip_cnt    <= '0;
         discard     <= 1'b0;
         blob_start  <= 1'b0;
         count_valid <= 1'b0;
         timeout     <= 1'b0;
         gap_err     <= 1'b0;
         count       <= '0;
      end else begin
         blob_start  <= 1'b0;
         count_valid <= 1'b0;
         case (state)
            IDLE: begin
               if ((bus.i_start | bus.i_continuous) & !bus.i_abort) begin
                  state    <= ARM;
                  timeout  <= 1'b0;
                  gap_err  <= 1'b0;
                  skip_cnt <= '0;
               end
            end
            ARM: begin
               if (bus.i_abort) begin
                  state <= IDLE;
               end else if (bus.i_frame_start) begin
                  if (int'(skip_cnt) < FRAME_SKIP) begin
                     skip_cnt <= skip_cnt + 1'b1;
                  end else begin
                     state      <= START;
                     blob_start <= 1'b1;
                  end
               end
            end
            START: begin
               pix_cnt <= '0;
               state   <= STREAM;
               if (bus.i_abort) discard <= 1'b1;
            end
            STREAM: begin
               if (bus.i_abort) discard <= 1'b1;
               if (!bus.i_pix_valid | bus.i_frame_start) gap_err <= 1'b1;
               if (pix_cnt == PIX_LAST) begin
                  state   <= WAIT;
                  tmo_cnt <= '0;
               end else begin
                  pix_cnt <= pix_cnt + 1'b1;
               end
            end
            WAIT: begin
               // A result arriving on the timeout cycle still wins over the timeout.
               if (bus.i_blob_valid) begin
                  if (!drop) begin
                     count       <= bus.i_blob_count;
                     count_valid <= 1'b1;
                  end
                  state    <= (bus.i_continuous & !drop) ? ARM : IDLE;
                  skip_cnt <= '0;
                  discard  <= 1'b0;
               end else if (tmo_cnt == TMO_LAST) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
                  discard <= 1'b0;
               end else begin
                  if (bus.i_abort) discard <= 1'b1;
                  if (tmo_cnt != {TMO_W{1'b1}}) tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_blob_start  = blob_start;
   assign bus.o_blob_seq    = (state == STREAM) & bus.i_pix_valid & bus.i_pix_bin & !drop;
   assign bus.o_count       = count;
   assign bus.o_count_valid = count_valid;
   assign bus.o_busy        = (state != IDLE);
   assign bus.o_state       = state;
   assign bus.o_timeout     = timeout;
   assign bus.o_gap_err     = gap_err;

endmodule
